// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: cache-side initiator for the 256-bit block RAM responder.
// Each accepted miss runs an optional dirty-victim writeback, then an optional
// line fill, and finishes with a one-cycle resp_valid pulse.
// Optional watchdog: define CACHE_MEM_TIMEOUT_EN to abort RAM transactions
// that stall for TIMEOUT_CYC cycles. The default build has no watchdog.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// WB    | victim block write in progress (ram_en=1, ram_write=1)
// GAP   | one disabled cycle so the responder restarts before the fill
// FILL  | line read in progress (ram_en=1, ram_write=0)
// DONE  | request finished; resp_valid/resp_err follow on the next cycle
module cache_mem_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int BLOCK_W     = 256,
  parameter int MIN_WAIT    = 9,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_dirty,
  input  logic               req_fill,
  input  logic [ADDR_W-1:0]  req_wb_addr,
  input  logic [BLOCK_W-1:0] req_wb_block,
  input  logic [ADDR_W-1:0]  req_fill_addr,
  output logic               resp_valid,
  output logic [BLOCK_W-1:0] resp_block,
  output logic               resp_err,
  output logic               ram_en,
  output logic               ram_write,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [BLOCK_W-1:0] data_to_ram,
  input  logic               ram_rdy,
  input  logic [BLOCK_W-1:0] block_out
);

  typedef enum logic [2:0] {IDLE, WB, GAP, FILL, DONE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(MIN_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic               fill_q;
  logic               abort_q;
  logic [ADDR_W-1:0]  fill_addr_q;
  logic               accept;
  logic               in_xfer;
  logic               xfer_done;
  logic               timeout_hit;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign in_xfer   = (state == WB) || (state == FILL);
  // Early ram_rdy is ignored: it may still be high from the previous same-type op.
  assign xfer_done = in_xfer && ram_rdy && (wait_cnt >= CNT_DONE);

`ifdef CACHE_MEM_TIMEOUT_EN
  // Abort on the last allowed cycle so ram_en is high for exactly TIMEOUT_CYC cycles.
  localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(TIMEOUT_CYC - 1);
  assign timeout_hit = in_xfer && !xfer_done && (wait_cnt >= CNT_TO);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: writeback, gap, fill, done sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_dirty)     state_nxt = WB;
          else if (req_fill) state_nxt = FILL;
          else               state_nxt = DONE;
        end
      end
      WB: begin
        if (xfer_done)        state_nxt = fill_q ? GAP : DONE;
        else if (timeout_hit) state_nxt = DONE;
      end
      GAP:  state_nxt = FILL;
      FILL: begin
        if (xfer_done || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-transaction wait counter: restarts on every state change, saturates.
  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state))         wait_cnt <= '0;
    else if (in_xfer && (wait_cnt != CNT_MAX)) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Latch the request fields still needed after accept; track watchdog aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q      <= 1'b0;
      fill_addr_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      if (accept) begin
        fill_q      <= req_fill;
        fill_addr_q <= req_fill_addr;
        abort_q     <= 1'b0;
      end else if (timeout_hit) begin
        abort_q     <= 1'b1;
      end
    end
  end

  // Registered RAM interface, aligned with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en      <= 1'b0;
      ram_write   <= 1'b0;
      ram_addr    <= '0;
      data_to_ram <= '0;
    end else begin
      ram_en    <= (state_nxt == WB) || (state_nxt == FILL);
      ram_write <= (state_nxt == WB);
      if (accept && req_dirty) begin
        ram_addr    <= req_wb_addr;
        data_to_ram <= req_wb_block;
      end else if (accept && req_fill) begin
        ram_addr    <= req_fill_addr;
      end else if (state == GAP) begin
        ram_addr    <= fill_addr_q;
      end
    end
  end

  // Response: capture fill data on completion, pulse resp_valid after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_block <= '0;
    end else begin
      resp_valid <= (state == DONE);
      resp_err   <= (state == DONE) && abort_q;
      if ((state == FILL) && xfer_done) resp_block <= block_out;
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: the whole run is planned up front as per-cycle
// input and expectation tables computed from cycle arithmetic, then replayed.
module tb_cache_mem_ctrl;
  localparam int ADDR_W      = 11;
  localparam int BLOCK_W     = 256;
  localparam int MIN_WAIT    = 9;
  localparam int TIMEOUT_CYC = 64;
  localparam int NCYC        = 4096;

  logic               clk = 1'b1;
  logic               rst, req_valid, req_ready, req_dirty, req_fill;
  logic [ADDR_W-1:0]  req_wb_addr, req_fill_addr, ram_addr;
  logic [BLOCK_W-1:0] req_wb_block, resp_block, data_to_ram, block_out;
  logic               resp_valid, resp_err, ram_en, ram_write, ram_rdy;

  cache_mem_ctrl #(
    .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .MIN_WAIT(MIN_WAIT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dirty(req_dirty), .req_fill(req_fill),
    .req_wb_addr(req_wb_addr), .req_wb_block(req_wb_block), .req_fill_addr(req_fill_addr),
    .resp_valid(resp_valid), .resp_block(resp_block), .resp_err(resp_err),
    .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr), .data_to_ram(data_to_ram),
    .ram_rdy(ram_rdy), .block_out(block_out)
  );

  always #5 clk = ~clk;

  // stimulus tables
  logic               drv_rst [NCYC];
  logic               drv_valid [NCYC];
  logic               drv_dirty [NCYC];
  logic               drv_fill [NCYC];
  logic [ADDR_W-1:0]  drv_wb_addr [NCYC];
  logic [ADDR_W-1:0]  drv_fill_addr [NCYC];
  logic [BLOCK_W-1:0] drv_wb_block [NCYC];
  logic               drv_rdy [NCYC];
  logic [BLOCK_W-1:0] drv_bo [NCYC];
  // expectation tables
  logic               exp_en [NCYC];
  logic               exp_wr [NCYC];
  logic [ADDR_W-1:0]  exp_addr [NCYC];
  logic [BLOCK_W-1:0] exp_data [NCYC];
  logic               exp_busy [NCYC];
  logic               exp_rv [NCYC];
  logic               exp_err [NCYC];
  logic [BLOCK_W-1:0] exp_blk [NCYC];
  // observed values for the hand-computed checks
  logic               rec_en [NCYC];
  logic               rec_wr [NCYC];
  logic               rec_rv [NCYC];
  logic               rec_err [NCYC];
  logic [ADDR_W-1:0]  rec_addr [NCYC];
  logic [BLOCK_W-1:0] rec_blk [NCYC];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = -1;
  int free_at     = 0;
  int prev_acc    = 0;
  int last_cyc    = 0;
  logic [BLOCK_W-1:0] held_blk = '0;

  function automatic logic [BLOCK_W-1:0] rand_block();
    logic [BLOCK_W-1:0] b;
    for (int i = 0; i < BLOCK_W/32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk(input string name, input int c,
                     input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, expv);
    end
  endtask

  // Length of one RAM transaction whose rdy first appears at index d.
  task automatic win_len(input int d, output int len, output bit ab);
    int k;
    k   = (d < MIN_WAIT - 1) ? MIN_WAIT - 1 : d;
    ab  = 1'b0;
    len = k + 1;
`ifdef CACHE_MEM_TIMEOUT_EN
    if (k >= TIMEOUT_CYC) begin
      ab  = 1'b1;
      len = TIMEOUT_CYC;
    end
`endif
  endtask

  task automatic plan_window(input int st, input int len, input int d, input bit stale,
                             input bit wr, input logic [ADDR_W-1:0] ad,
                             input logic [BLOCK_W-1:0] dat);
    for (int c = st; c < st + len; c++) begin
      exp_en[c]   = 1'b1;
      exp_wr[c]   = wr;
      exp_addr[c] = ad;
      exp_data[c] = dat;
      if (stale || (c - st >= d)) drv_rdy[c] = 1'b1;
    end
    if (stale) drv_rdy[st-1] = 1'b1;
  endtask

  task automatic plan_req(input int issue, input bit dirty, input bit fill,
                          input logic [ADDR_W-1:0] wa, input logic [BLOCK_W-1:0] wblk,
                          input logic [ADDR_W-1:0] fa, input int dw, input int df,
                          input logic [BLOCK_W-1:0] fblk, input bit stale, output int acc);
    int a, t, len, dwe, dfe;
    bit ab;
    a = (issue > free_at) ? issue : free_at;
    for (int c = issue; c <= a; c++) begin
      drv_valid[c]     = 1'b1;
      drv_dirty[c]     = dirty;
      drv_fill[c]      = fill;
      drv_wb_addr[c]   = wa;
      drv_wb_block[c]  = wblk;
      drv_fill_addr[c] = fa;
    end
    dwe = stale ? 0 : dw;
    dfe = stale ? 0 : df;
    t   = a + 1;
    ab  = 1'b0;
    if (dirty) begin
      win_len(dwe, len, ab);
      plan_window(t, len, dwe, stale, 1'b1, wa, wblk);
      t += len;
    end
    if (fill && !ab) begin
      if (dirty) t++;
      win_len(dfe, len, ab);
      plan_window(t, len, dfe, stale, 1'b0, fa, '0);
      if (!ab) begin
        drv_bo[t+len-1] = fblk;
        held_blk        = fblk;
      end
      t += len;
    end
    for (int c = a + 1; c <= t; c++) exp_busy[c] = 1'b1;
    exp_rv[t+1]  = 1'b1;
    exp_err[t+1] = ab;
    exp_blk[t+1] = held_blk;
    free_at  = t + 1;
    prev_acc = a;
    acc      = a;
    if (t + 2 > last_cyc) last_cyc = t + 2;
  endtask

  task automatic plan_reset(input int r);
    drv_rst[r] = 1'b1;
    for (int c = r + 1; c < NCYC; c++) begin
      exp_en[c]   = 1'b0;
      exp_busy[c] = 1'b0;
      exp_rv[c]   = 1'b0;
      exp_err[c]  = 1'b0;
      drv_rdy[c]  = 1'b0;
    end
    held_blk = '0;
    free_at  = r + 1;
  endtask

  // Compare process: every cycle, DUT outputs against the planned expectations.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc <= last_cyc) begin
      rec_en[cyc]   = ram_en;
      rec_wr[cyc]   = ram_write;
      rec_rv[cyc]   = resp_valid;
      rec_err[cyc]  = resp_err;
      rec_addr[cyc] = ram_addr;
      rec_blk[cyc]  = resp_block;
      chk("ram_en", cyc, ram_en, exp_en[cyc]);
      if (exp_en[cyc]) begin
        chk("ram_write", cyc, ram_write, exp_wr[cyc]);
        chk("ram_addr", cyc, ram_addr, exp_addr[cyc]);
        if (exp_wr[cyc]) chk("data_to_ram", cyc, data_to_ram, exp_data[cyc]);
      end
      if (!drv_rst[cyc]) chk("req_ready", cyc, req_ready, !exp_busy[cyc]);
      chk("resp_valid", cyc, resp_valid, exp_rv[cyc]);
      chk("resp_err", cyc, resp_err, exp_err[cyc]);
      if (exp_rv[cyc]) chk("resp_block", cyc, resp_block, exp_blk[cyc]);
      if (cyc == 3) begin
        chk("rst_resp_block", cyc, resp_block, '0);
        chk("rst_ram_addr", cyc, ram_addr, '0);
        chk("rst_data_to_ram", cyc, data_to_ram, '0);
        chk("rst_ram_write", cyc, ram_write, 1'b0);
      end
    end
  end

  initial begin
    int a1, a2, a3, ab1, ab2, an, ar, a5, al, ald, issue, tmp;
    logic [BLOCK_W-1:0] lit_blk;
    for (int c = 0; c < NCYC; c++) begin
      drv_rst[c] = 1'b0; drv_valid[c] = 1'b0; drv_dirty[c] = 1'b0; drv_fill[c] = 1'b0;
      drv_wb_addr[c] = '0; drv_fill_addr[c] = '0; drv_wb_block[c] = '0;
      drv_rdy[c] = 1'b0; drv_bo[c] = rand_block();
      exp_en[c] = 1'b0; exp_wr[c] = 1'b0; exp_addr[c] = '0; exp_data[c] = '0;
      exp_busy[c] = 1'b0; exp_rv[c] = 1'b0; exp_err[c] = 1'b0; exp_blk[c] = '0;
    end
    for (int c = 0; c < 3; c++) drv_rst[c] = 1'b1;
    free_at = 3;

    lit_blk = 256'h201f1e1d1c1b1a191817161514131211100f0e0d0c0b0a090807060504030201;
    plan_req(5, 1'b0, 1'b1, '0, '0, 11'h123, 0, 8, lit_blk, 1'b0, a1);
    plan_req(free_at + 2, 1'b1, 1'b1, 11'h010, rand_block(), 11'h7FF, 8, 8, rand_block(), 1'b0, a2);
    plan_req(free_at + 1, 1'b0, 1'b1, '0, '0, 11'h2AA, 0, 0, rand_block(), 1'b1, a3);
    // back-to-back with req_valid held throughout, ending in a no-op request
    plan_req(free_at, 1'b0, 1'b1, '0, '0, 11'h055, 3, 12, rand_block(), 1'b0, ab1);
    plan_req(ab1 + 1, 1'b0, 1'b1, '0, '0, 11'h3C3, 8, 8, rand_block(), 1'b0, ab2);
    plan_req(ab2 + 1, 1'b0, 1'b0, 11'h111, rand_block(), 11'h222, 8, 8, rand_block(), 1'b0, an);
    // reset on the fifth fill cycle, then a normal request
    plan_req(free_at + 2, 1'b0, 1'b1, '0, '0, 11'h0F0, 8, 8, rand_block(), 1'b0, ar);
    plan_reset(ar + 5);
    plan_req(free_at + 1, 1'b0, 1'b1, '0, '0, 11'h00F, 8, 8, rand_block(), 1'b0, a5);
    // long stalls: beyond the watchdog limit and past the counter range
    plan_req(free_at + 1, 1'b0, 1'b1, '0, '0, 11'h444, 0, 130, rand_block(), 1'b0, al);
    plan_req(free_at + 1, 1'b1, 1'b1, 11'h555, rand_block(), 11'h666, 100, 8, rand_block(), 1'b0, ald);

    while (free_at < NCYC - 200) begin
      bit dirty, fill, stale;
      int dw, df;
      dirty = $urandom_range(0, 1);
      fill  = $urandom_range(0, 3) != 0;
      stale = $urandom_range(0, 4) == 0;
      dw    = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 20);
      df    = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 20);
      issue = free_at - 4 + $urandom_range(0, 6);
      if (issue < prev_acc + 1) issue = prev_acc + 1;
      plan_req(issue, dirty, fill, 11'($urandom), rand_block(), 11'($urandom),
               dw, df, rand_block(), stale, tmp);
    end

    for (int c = 0; c <= last_cyc; c++) begin
      cyc           = c;
      rst           = drv_rst[c];
      req_valid     = drv_valid[c];
      req_dirty     = drv_dirty[c];
      req_fill      = drv_fill[c];
      req_wb_addr   = drv_wb_addr[c];
      req_wb_block  = drv_wb_block[c];
      req_fill_addr = drv_fill_addr[c];
      ram_rdy       = drv_rdy[c];
      block_out     = drv_bo[c];
      @(negedge clk);
      @(posedge clk);
      #1;
    end

    // hand-computed expectations
    chk("lit_fill_resp", a1 + 11, rec_rv[a1+11], 1'b1);
    chk("lit_fill_blk", a1 + 11, rec_blk[a1+11], lit_blk);
    chk("lit_fill_addr", a1 + 1, rec_addr[a1+1], 11'h123);
    chk("lit_fill_wr", a1 + 1, rec_wr[a1+1], 1'b0);
    chk("lit_fill_en_last", a1 + 9, rec_en[a1+9], 1'b1);
    chk("lit_fill_en_off", a1 + 10, rec_en[a1+10], 1'b0);
    chk("lit_df_resp", a2 + 21, rec_rv[a2+21], 1'b1);
    chk("lit_df_wr", a2 + 1, rec_wr[a2+1], 1'b1);
    chk("lit_df_wb_addr", a2 + 1, rec_addr[a2+1], 11'h010);
    chk("lit_df_gap", a2 + 10, rec_en[a2+10], 1'b0);
    chk("lit_df_fill_en", a2 + 11, rec_en[a2+11], 1'b1);
    chk("lit_df_fill_addr", a2 + 11, rec_addr[a2+11], 11'h7FF);
    chk("lit_df_fill_wr", a2 + 11, rec_wr[a2+11], 1'b0);
    chk("lit_stale_en_last", a3 + 9, rec_en[a3+9], 1'b1);
    chk("lit_stale_en_off", a3 + 10, rec_en[a3+10], 1'b0);
    chk("lit_none_resp", an + 2, rec_rv[an+2], 1'b1);
    chk("lit_none_en", an + 1, rec_en[an+1], 1'b0);
    chk("lit_rst_en", ar + 6, rec_en[ar+6], 1'b0);
    chk("lit_after_rst_resp", a5 + 11, rec_rv[a5+11], 1'b1);
`ifdef CACHE_MEM_TIMEOUT_EN
    chk("lit_to_en_last", al + 64, rec_en[al+64], 1'b1);
    chk("lit_to_en_off", al + 65, rec_en[al+65], 1'b0);
    chk("lit_to_resp", al + 66, rec_rv[al+66], 1'b1);
    chk("lit_to_err", al + 66, rec_err[al+66], 1'b1);
`else
    chk("lit_long_en_last", al + 131, rec_en[al+131], 1'b1);
    chk("lit_long_en_off", al + 132, rec_en[al+132], 1'b0);
    chk("lit_long_resp", al + 133, rec_rv[al+133], 1'b1);
    chk("lit_long_err", al + 133, rec_err[al+133], 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
